// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default word/synchronizer sizing.
// Used by both the SPI slave and the SPI master.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int SPI_DATA_WIDTH  = 16;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_if.sv
// Four-wire SPI bus; the master drives sclk/ss_n/mosi and the slave drives miso.
interface spi_slave_if;

  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output ss_n, output mosi, input miso);
  modport slave  (input sclk, input ss_n, input mosi, output miso);

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  // Fewer than two flops does not give metastability a full cycle to settle
  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [DEPTH-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= {DEPTH{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four CPOL/CPHA modes, oversampling sclk/ss_n/mosi in the clk domain.
// Supports back-to-back words under one ss_n and a persistent, resendable tx buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  spi_slave_if.slave            spi,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_sclk_s;
  logic w_ss_n_s;
  logic w_mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (spi.sclk),
    .o_sync  (w_sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (spi.ss_n),
    .o_sync  (w_ss_n_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (spi.mosi),
    .o_sync  (w_mosi_s)
  );

  spi_state_t              r_state;
  spi_state_t              w_state_next;
  logic                    r_sclk_d;
  logic                    r_cpol;
  logic                    r_cpha;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_tx_buffer;
  logic [DATA_WIDTH-1:0]   r_tx_shift;
  logic [DATA_WIDTH-2:0]   r_rx_shift;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_rx_valid;
  logic                    w_miso;

  logic                    w_edge;
  logic                    w_lead;
  logic                    w_trail;
  logic                    w_sample;
  logic                    w_shift;
  logic [DATA_WIDTH-1:0]   w_tx_src;

  // Leading edge leaves the idle level, trailing edge returns to it
  assign w_edge   = w_sclk_s ^ r_sclk_d;
  assign w_lead   = w_edge & (w_sclk_s != r_cpol);
  assign w_trail  = w_edge & (w_sclk_s == r_cpol);
  assign w_sample = r_cpha ? w_trail : w_lead;
  assign w_shift  = r_cpha ? w_lead  : w_trail;
  assign w_tx_src = tx_load ? tx_data : r_tx_buffer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_ss_n_s) w_state_next = ACTIVE;
      ACTIVE:  if (w_ss_n_s)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    w_miso = 1'b0;
    if (r_state == ACTIVE) begin
      busy   = 1'b1;
      w_miso = r_tx_shift[DATA_WIDTH-1];
    end
  end

  assign spi.miso = w_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_d    <= 1'b0;
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx_buffer <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk_s;
      r_rx_valid <= 1'b0;
      if (tx_load) begin
        r_tx_buffer <= tx_data;
      end
      case (r_state)
        IDLE: begin
          if (!w_ss_n_s) begin
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_bit_cnt  <= '0;
            r_tx_shift <= w_tx_src;
          end
        end
        ACTIVE: begin
          // A deselect in the same cycle as an sclk edge drops the edge
          if (!w_ss_n_s) begin
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], w_mosi_s};
              if (r_bit_cnt == LAST_BIT) begin
                r_rx_data  <= {r_rx_shift, w_mosi_s};
                r_rx_valid <= 1'b1;
                r_bit_cnt  <= '0;
                r_tx_shift <= w_tx_src;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end else if (w_shift && (r_bit_cnt != '0)) begin
              r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets bits per SPI word.
REQ-002 Parameter SYNC_STAGES, default 2, sets flip-flop depth of input synchronizers (minimum 2).
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 cpol  input  1  idle level of sclk.
REQ-006 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-007 tx_data  input  DATA_WIDTH  next word to transmit on miso.
REQ-008 tx_load  input  1  one-cycle strobe writing tx_data into tx_buffer.
REQ-009 sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-010 ss_n  input  1  active-low slave select, asynchronous.
REQ-011 mosi  input  1  serial data from master, asynchronous.
REQ-012 miso  output  1  serial data to master, MSB first.
REQ-013 busy  output  1  high while in ACTIVE state.
REQ-014 rx_data  output  DATA_WIDTH  last complete received word.
REQ-015 rx_valid  output  1  one-cycle pulse when rx_data updates.

Function
REQ-016 sclk, ss_n and mosi SHALL each pass through a SYNC_STAGES synchronizer; all logic uses only synchronized copies.
REQ-017 An sclk edge SHALL be detected when the synchronized sclk differs from its one-cycle-delayed copy; leading = departing cpol, trailing = returning to cpol.
REQ-018 Sample edge SHALL be leading when cpha=0 and trailing when cpha=1; shift edge is the other one.
REQ-019 State machine SHALL have states IDLE and ACTIVE only.
REQ-020 IDLE -> ACTIVE SHALL occur on the first cycle synchronized ss_n is low; on that cycle cpol/cpha are latched, bit_cnt cleared, tx_shift loaded from tx_buffer.
REQ-021 Latched cpol/cpha SHALL govern the whole transaction; changes on the ports while ACTIVE are ignored.
REQ-022 ACTIVE -> IDLE SHALL occur on the first cycle synchronized ss_n is high, regardless of bit_cnt; a partial word is discarded, no rx_valid, rx_data unchanged.
REQ-023 If ss_n deassertion and an sclk edge are detected in the same cycle, deassertion SHALL win and the edge is ignored.
REQ-024 On a sample edge, rx_shift SHALL shift left taking synchronized mosi into bit 0, and bit_cnt SHALL increment.
REQ-025 When the sample makes bit_cnt reach DATA_WIDTH: rx_data <= completed word and rx_valid = 1 for exactly one cycle (same clk edge), bit_cnt <= 0, tx_shift reloaded from tx_buffer; transfer continues without leaving ACTIVE (back-to-back words).
REQ-026 On a shift edge, tx_shift SHALL shift left by one only when bit_cnt != 0; otherwise it holds (keeps the MSB of a freshly loaded word).
REQ-027 miso SHALL equal tx_shift[DATA_WIDTH-1] in ACTIVE and 0 in IDLE.
REQ-028 tx_load SHALL update tx_buffer in any state; tx_buffer persists and is resent if not reloaded.
REQ-029 If tx_load coincides with a tx_shift load (REQ-020/REQ-025), tx_data SHALL be loaded directly (bypass).
REQ-030 sclk edges while IDLE SHALL be ignored.
REQ-031 Correct operation requires clk frequency >= 4x sclk frequency; out-of-range behaviour is unspecified.

Reset
REQ-032 reset_n low SHALL asynchronously force: state IDLE, miso 0, busy 0, rx_data 0, rx_valid 0, tx_buffer 0, tx_shift 0, rx_shift 0, bit_cnt 0, synchronizers to sclk=0, ss_n=1, mosi=0.
REQ-033 Reset asserted mid-transaction SHALL abort without rx_valid; after release the block waits for a fresh ss_n low.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum (IDLE, ACTIVE), default DATA_WIDTH and SYNC_STAGES constants, shared with the SPI master.
REQ-035 Sub-module spi_sync (parameterized-depth synchronizer with reset value parameter) SHALL be instantiated once per asynchronous input.

Verification (behavioural SPI master model, clk = 8x sclk)
REQ-036 Mode 0 (cpol=0,cpha=0), tx_buffer=16'hA5C3, master sends 16'h1234 -> rx_data=16'h1234 with one rx_valid pulse; master receives 16'hA5C3.
REQ-037 Mode 3 (cpol=1,cpha=1), tx_buffer=16'h8001, master sends 16'hFFFE -> rx_data=16'hFFFE; master receives 16'h8001.
REQ-038 Mode 1, two back-to-back words 16'h0F0F, 16'hF0F0 under one ss_n, tx_load 16'h3C3C between words -> two rx_valid pulses in order; master receives tx_buffer word then 16'h3C3C.
REQ-039 ss_n raised after 7 bits of 16'hBEEF -> no rx_valid, rx_data unchanged, busy low within SYNC_STAGES+1 cycles; next full word 16'h0001 received correctly.
REQ-040 reset_n pulsed low mid-word -> all outputs at REQ-032 values immediately; subsequent mode 2 transfer of 16'h5555 completes correctly.
